// File: rtl/fpu_sub_pkg.sv
// Shared types and constants for the FP32 subtract datapath and its rounder.
package fpu_sub_pkg;

    typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;

    localparam logic [7:0]  EXP_MAX        = 8'hFF;
    localparam int          SIG_W          = 26;
    localparam logic [24:0] CANON_NAN_FRAC = 25'h1000000;

    // Rounding-mode encodings consumed by the downstream rounder.
    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RZE = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

endpackage

// File: rtl/fp_lzc26.sv
// Combinational leading-zero count of a 26-bit value; returns 26 for zero.
module fp_lzc26 (
    input  logic [25:0] val_i,
    output logic [4:0]  cnt_o
);

    always_comb begin
        cnt_o = 5'd26;
        // Ascending scan, so the highest set bit writes last and wins.
        for (int i = 0; i < 26; i++) begin
            if (val_i[i]) cnt_o = 5'(25 - i);
        end
    end

endmodule

// File: rtl/fp_sub_align_norm.sv
// FP32 fp1 - fp2: unpack, magnitude swap, align, add/sub, normalise; unrounded output.
// Define FP_SUB_STICKY_EN to OR bits lost during alignment/overflow shifts into bit0.
module fp_sub_align_norm
    import fpu_sub_pkg::*;
#(
    parameter int GUARD_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp1,
    input  logic [31:0] fp2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [7:0]  exp_out,
    output logic [24:0] fraction,
    output logic        carry_out,
    output logic        special
);

    state_t state_q, state_d;

    logic             sa_q, sb_q, spec_q, nan_q, spec_sign_q;
    logic [7:0]       ea_q, eb_q;
    logic [SIG_W-1:0] siga_q, sigb_q;
    logic [SIG_W-1:0] big_q, small_q;
    logic [7:0]       exp_q;
    logic             sgn_q, sub_q, carry_q;
    logic [SIG_W:0]   sum_q;
    logic             res_sign_q, res_carry_q, res_special_q;
    logic [7:0]       res_exp_q;
    logic [24:0]      res_frac_q;

    // Unpack: b carries the inverted sign so the core only ever adds.
    logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic [SIG_W-1:0] siga_d, sigb_d;
    always_comb begin
        a_zero = (fp1[30:23] == 8'd0);
        b_zero = (fp2[30:23] == 8'd0);
        a_nan  = (fp1[30:23] == EXP_MAX) && (fp1[22:0] != 23'd0);
        b_nan  = (fp2[30:23] == EXP_MAX) && (fp2[22:0] != 23'd0);
        a_inf  = (fp1[30:23] == EXP_MAX) && (fp1[22:0] == 23'd0);
        b_inf  = (fp2[30:23] == EXP_MAX) && (fp2[22:0] == 23'd0);
        siga_d = a_zero ? '0 : {1'b1, fp1[22:0], {GUARD_W{1'b0}}};
        sigb_d = b_zero ? '0 : {1'b1, fp2[22:0], {GUARD_W{1'b0}}};
    end

    logic             swap;
    logic [7:0]       shamt;
    logic [SIG_W-1:0] sig_sm, small_d;
    always_comb begin
        swap    = {eb_q, sigb_q} > {ea_q, siga_q};
        sig_sm  = swap ? siga_q : sigb_q;
        shamt   = swap ? (eb_q - ea_q) : (ea_q - eb_q);
        small_d = sig_sm >> shamt;
`ifdef FP_SUB_STICKY_EN
        small_d[0] = small_d[0] | (|(sig_sm & ~({SIG_W{1'b1}} << shamt)));
`endif
    end

    logic [4:0]  lz;
    logic        res_sign_d, res_special_d;
    logic [7:0]  res_exp_d;
    logic [24:0] res_frac_d;

    fp_lzc26 u_lzc (
        .val_i (sum_q[SIG_W-1:0]),
        .cnt_o (lz)
    );

    always_comb begin
        res_sign_d    = sgn_q;
        res_exp_d     = 8'd0;
        res_frac_d    = 25'd0;
        res_special_d = 1'b0;
        if (spec_q) begin
            res_special_d = 1'b1;
            res_exp_d     = EXP_MAX;
            res_sign_d    = nan_q ? 1'b0 : spec_sign_q;
            res_frac_d    = nan_q ? CANON_NAN_FRAC : 25'd0;
        end else if (sum_q[SIG_W]) begin
            if (exp_q == EXP_MAX - 8'd1) begin
                res_exp_d = EXP_MAX;
            end else begin
                res_exp_d  = exp_q + 8'd1;
                res_frac_d = sum_q[25:1];
`ifdef FP_SUB_STICKY_EN
                res_frac_d[0] = sum_q[1] | sum_q[0];
`endif
            end
        end else if (sum_q[SIG_W-1:0] == '0) begin
            res_sign_d = 1'b0;
        end else if ({3'b0, lz} < exp_q) begin
            res_exp_d  = exp_q - {3'b0, lz};
            res_frac_d = sum_q[24:0] << lz;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ALIGN;
            ALIGN:   state_d = ADDSUB;
            ADDSUB:  state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            {sa_q, sb_q, spec_q, nan_q, spec_sign_q} <= '0;
            {ea_q, eb_q, siga_q, sigb_q}             <= '0;
            {big_q, small_q, exp_q}                  <= '0;
            {sgn_q, sub_q, carry_q, sum_q}           <= '0;
            {res_sign_q, res_carry_q, res_special_q} <= '0;
            {res_exp_q, res_frac_q}                  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (in_valid) begin
                    sa_q        <= fp1[31];
                    sb_q        <= ~fp2[31];
                    ea_q        <= fp1[30:23];
                    eb_q        <= fp2[30:23];
                    siga_q      <= siga_d;
                    sigb_q      <= sigb_d;
                    spec_q      <= a_nan | b_nan | a_inf | b_inf;
                    nan_q       <= a_nan | b_nan | (a_inf & b_inf & (fp1[31] == fp2[31]));
                    spec_sign_q <= a_inf ? fp1[31] : ~fp2[31];
                end
                ALIGN: begin
                    big_q   <= swap ? sigb_q : siga_q;
                    small_q <= small_d;
                    exp_q   <= swap ? eb_q : ea_q;
                    sgn_q   <= swap ? sb_q : sa_q;
                    sub_q   <= sa_q ^ sb_q;
                    carry_q <= ~swap;
                end
                ADDSUB: sum_q <= sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                       : ({1'b0, big_q} + {1'b0, small_q});
                NORM: begin
                    res_sign_q    <= res_sign_d;
                    res_exp_q     <= res_exp_d;
                    res_frac_q    <= res_frac_d;
                    res_special_q <= res_special_d;
                    res_carry_q   <= carry_q;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sign      = res_sign_q;
    assign exp_out   = res_exp_q;
    assign fraction  = res_frac_q;
    assign carry_out = res_carry_q;
    assign special   = res_special_q;

endmodule

// File: tb/tb_fp_sub_align_norm.sv
// Directed-vector bench for fp_sub_align_norm with hand-computed expectations.
module tb_fp_sub_align_norm;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] fp1, fp2;
    logic        sign, carry_out, special;
    logic [7:0]  exp_out;
    logic [24:0] fraction;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_sub_align_norm dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp1       (fp1),
        .fp2       (fp2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .exp_out   (exp_out),
        .fraction  (fraction),
        .carry_out (carry_out),
        .special   (special)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s_e, input logic [7:0] e_e, input logic [24:0] f_e,
                         input logic c_e, input logic sp_e, input int hold);
        int lat;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        fp1 = a;
        fp2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd4);
        chk({tag, ".sign"},    32'(sign),      32'(s_e));
        chk({tag, ".exp"},     32'(exp_out),   32'(e_e));
        chk({tag, ".frac"},    32'(fraction),  32'(f_e));
        chk({tag, ".carry"},   32'(carry_out), 32'(c_e));
        chk({tag, ".special"}, 32'(special),   32'(sp_e));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_rdy"},   32'(in_ready),  32'd0);
            chk({tag, ".hold_res"},   {sign, exp_out, fraction[22:0]}, {s_e, e_e, f_e[22:0]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        $display("op %-10s %h - %h -> s=%0d e=%h f=%h c=%0d sp=%0d lat=%0d",
                 tag, a, b, sign, exp_out, fraction, carry_out, special, lat);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        fp1 = '0;
        fp2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.outs", {7'd0, sign, exp_out, fraction, carry_out, special}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("3-1",      32'h40400000, 32'h3F800000, 1'b0, 8'h80, 25'h0,       1'b1, 1'b0, 0);
        do_op("1-3",      32'h3F800000, 32'h40400000, 1'b1, 8'h80, 25'h0,       1'b0, 1'b0, 0);
        do_op("1-1",      32'h3F800000, 32'h3F800000, 1'b0, 8'h00, 25'h0,       1'b1, 1'b0, 0);
        do_op("1+1",      32'h3F800000, 32'hBF800000, 1'b0, 8'h80, 25'h0,       1'b1, 1'b0, 0);
        do_op("1.5-.25",  32'h3FC00000, 32'h3E800000, 1'b0, 8'h7F, 25'h0800000, 1'b1, 1'b0, 0);
        do_op("1-.75",    32'h3F800000, 32'h3F400000, 1'b0, 8'h7D, 25'h0,       1'b1, 1'b0, 0);
        do_op("1-2^-24",  32'h3F800000, 32'h33800000, 1'b0, 8'h7E, 25'h1FFFFFC, 1'b1, 1'b0, 0);
        do_op("1-2^-25",  32'h3F800000, 32'h33000000, 1'b0, 8'h7E, 25'h1FFFFFE, 1'b1, 1'b0, 0);
`ifdef FP_SUB_STICKY_EN
        do_op("1-2^-26",  32'h3F800000, 32'h32800000, 1'b0, 8'h7E, 25'h1FFFFFE, 1'b1, 1'b0, 0);
`else
        do_op("1-2^-26",  32'h3F800000, 32'h32800000, 1'b0, 8'h7F, 25'h0,       1'b1, 1'b0, 0);
`endif
        do_op("max+max",  32'h7F7FFFFF, 32'hFF7FFFFF, 1'b0, 8'hFF, 25'h0,       1'b1, 1'b0, 0);
        do_op("uflow",    32'h00800001, 32'h00800000, 1'b0, 8'h00, 25'h0,       1'b1, 1'b0, 0);
        do_op("0-1",      32'h00000000, 32'h3F800000, 1'b1, 8'h7F, 25'h0,       1'b0, 1'b0, 0);
        do_op("nan",      32'h7FC00001, 32'h3F800000, 1'b0, 8'hFF, 25'h1000000, 1'b1, 1'b1, 3);
        do_op("1-inf",    32'h3F800000, 32'h7F800000, 1'b1, 8'hFF, 25'h0,       1'b0, 1'b1, 0);
        do_op("inf-inf",  32'h7F800000, 32'h7F800000, 1'b0, 8'hFF, 25'h1000000, 1'b1, 1'b1, 0);
        do_op("-inf-inf", 32'hFF800000, 32'h7F800000, 1'b1, 8'hFF, 25'h0,       1'b1, 1'b1, 0);

        // Abort an operation with an asynchronous reset while it sits in ADDSUB.
        in_valid = 1'b1;
        fp1 = 32'h40400000;
        fp2 = 32'h3F800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort.in_ready",  32'(in_ready),  32'd1);
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort.no_result", 32'(out_valid), 32'd0);
        end
        $display("op abort     reset during ADDSUB -> in_ready=%0d out_valid=%0d", in_ready, out_valid);
        do_op("post-rst", 32'h3F800000, 32'h40400000, 1'b1, 8'h80, 25'h0,       1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
